instr_fetch: RTL and testbench

- Fetch stage directly downstream of the program counter register.
- On a request from the control FSM, it samples the current 16-bit PC and issues a word read to instruction memory.
- It waits for the memory ready handshake, then latches the returned word into the instruction register (IR) together with the address it came from.
- It supplies IR to decode and IR_PC to branch/jump target logic.

---
 rtl/instr_fetch.sv | 125 ++++++++++++
 tb/tb_instr_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: samples PC on a fetch request, issues a word read to
// instruction memory, waits for MEM_RDY and latches the returned word into
// IR together with its source address (IR_PC).
// Optional feature macro: FETCH_TIMEOUT_EN compiles in a per-fetch wait
// counter that aborts the read after MAX_WAIT unready cycles and raises the
// sticky FETCH_ERR flag.
module instr_fetch #(
    parameter int unsigned MAX_WAIT = 15  // legal range 1..255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] PC,
    input  logic        FETCH,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_RD,
    input  logic [15:0] MEM_DATA,
    input  logic        MEM_RDY,
    output logic [15:0] IR,
    output logic [15:0] IR_PC,
    output logic        IR_VALID,
    output logic        BUSY,
    output logic        FETCH_ERR
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state, state_next;
    logic   accept;       // request taken in IDLE this cycle
    logic   complete;     // memory returned data this cycle
    logic   abort_fetch;  // wait limit reached this cycle

`ifdef FETCH_TIMEOUT_EN
    // The abort fires on the edge that samples the MAX_WAIT-th unready
    // cycle, i.e. when the counter already holds MAX_WAIT-1.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
    logic [7:0] wait_cnt;
    logic       err_q;
`endif

    // Next-state and per-cycle control strobes
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        complete    = 1'b0;
        abort_fetch = 1'b0;
        case (state)
            IDLE: begin
                if (FETCH) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                // Data wins over the abort when both land on the same edge.
                if (MEM_RDY) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_cnt == WAIT_LAST) begin
                    abort_fetch = 1'b1;
                    state_next  = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // Address/strobe and instruction register updates
    always_ff @(posedge CLK) begin
        if (RESET) begin
            MEM_ADDR <= '0;
            MEM_RD   <= 1'b0;
            IR       <= '0;
            IR_PC    <= '0;
            IR_VALID <= 1'b0;
        end else if (accept) begin
            MEM_ADDR <= PC;  // frozen until the read finishes
            MEM_RD   <= 1'b1;
            IR_VALID <= 1'b0;
        end else if (complete) begin
            IR       <= MEM_DATA;
            IR_PC    <= MEM_ADDR;
            IR_VALID <= 1'b1;
            MEM_RD   <= 1'b0;
        end else if (abort_fetch) begin
            // IR/IR_PC keep the last good instruction; only the strobe drops.
            MEM_RD   <= 1'b0;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Wait counter: counts unready REQ cycles, saturates rather than wraps
    always_ff @(posedge CLK) begin
        if (RESET || accept) begin
            wait_cnt <= '0;
        end else if (state == REQ && !MEM_RDY && !abort_fetch && wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Sticky timeout flag, cleared by the next accepted fetch
    always_ff @(posedge CLK) begin
        if (RESET || accept) err_q <= 1'b0;
        else if (abort_fetch) err_q <= 1'b1;
    end

    assign FETCH_ERR = err_q;
`else
    assign FETCH_ERR = 1'b0;
`endif

    assign BUSY = (state == REQ);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Expected values are hand-computed; the
// timeout section is selected by FETCH_TIMEOUT_EN with MAX_WAIT=4.
module tb_instr_fetch;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] PC;
    logic        FETCH;
    logic [15:0] MEM_ADDR;
    logic        MEM_RD;
    logic [15:0] MEM_DATA;
    logic        MEM_RDY;
    logic [15:0] IR;
    logic [15:0] IR_PC;
    logic        IR_VALID;
    logic        BUSY;
    logic        FETCH_ERR;

    int checks   = 0;
    int failures = 0;

    instr_fetch #(.MAX_WAIT(4)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .PC       (PC),
        .FETCH    (FETCH),
        .MEM_ADDR (MEM_ADDR),
        .MEM_RD   (MEM_RD),
        .MEM_DATA (MEM_DATA),
        .MEM_RDY  (MEM_RDY),
        .IR       (IR),
        .IR_PC    (IR_PC),
        .IR_VALID (IR_VALID),
        .BUSY     (BUSY),
        .FETCH_ERR(FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge and settle; inputs changed afterwards are
    // stable well before the next edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    initial begin
        // Reset with FETCH and MEM_RDY both high: reset must win
        RESET = 1'b1; FETCH = 1'b1; MEM_RDY = 1'b1; PC = 16'h1234; MEM_DATA = 16'hFFFF;
        step(); step();
        check("rst_mem_addr", MEM_ADDR, 16'h0);
        check("rst_mem_rd",   {15'd0, MEM_RD}, 16'd0);
        check("rst_ir",       IR, 16'h0);
        check("rst_ir_pc",    IR_PC, 16'h0);
        check("rst_ir_valid", {15'd0, IR_VALID}, 16'd0);
        check("rst_busy",     {15'd0, BUSY}, 16'd0);
        check("rst_err",      {15'd0, FETCH_ERR}, 16'd0);
        RESET = 1'b0; FETCH = 1'b0; MEM_RDY = 1'b0;
        step();
        check("idle_hold_busy", {15'd0, BUSY}, 16'd0);

        // Zero-wait fetch
        PC = 16'd12; FETCH = 1'b1;
        step();
        check("zw_mem_addr", MEM_ADDR, 16'd12);
        check("zw_mem_rd",   {15'd0, MEM_RD}, 16'd1);
        check("zw_busy",     {15'd0, BUSY}, 16'd1);
        FETCH = 1'b0; MEM_RDY = 1'b1; MEM_DATA = 16'hA5C3;
        step();
        check("zw_ir",       IR, 16'hA5C3);
        check("zw_ir_pc",    IR_PC, 16'd12);
        check("zw_ir_valid", {15'd0, IR_VALID}, 16'd1);
        check("zw_busy_off", {15'd0, BUSY}, 16'd0);
        check("zw_rd_off",   {15'd0, MEM_RD}, 16'd0);

        // MEM_RDY/MEM_DATA ignored outside REQ
        MEM_RDY = 1'b1; MEM_DATA = 16'h1111;
        step();
        check("idle_rdy_ir",    IR, 16'hA5C3);
        check("idle_rdy_valid", {15'd0, IR_VALID}, 16'd1);
        MEM_RDY = 1'b0;

        // Wait states with PC changing and FETCH held high during the wait
        PC = 16'd13; FETCH = 1'b1;
        step();
        check("ws_accept_valid", {15'd0, IR_VALID}, 16'd0);
        PC = 16'd40;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ws_mem_addr", MEM_ADDR, 16'd13);
            check("ws_mem_rd",   {15'd0, MEM_RD}, 16'd1);
            check("ws_busy",     {15'd0, BUSY}, 16'd1);
        end
        FETCH = 1'b0; MEM_RDY = 1'b1; MEM_DATA = 16'hBEEF;
        step();
        check("ws_ir",       IR, 16'hBEEF);
        check("ws_ir_pc",    IR_PC, 16'd13);
        check("ws_ir_valid", {15'd0, IR_VALID}, 16'd1);
        check("ws_err",      {15'd0, FETCH_ERR}, 16'd0);
        MEM_RDY = 1'b0;
        step();
        check("ws_idle_after", {15'd0, BUSY}, 16'd0);

`ifdef FETCH_TIMEOUT_EN
        // Timeout at MAX_WAIT=4 on the top address
        PC = 16'hFFFF; FETCH = 1'b1;
        step();
        FETCH = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("to_busy_pre", {15'd0, BUSY}, 16'd1);
            check("to_err_pre",  {15'd0, FETCH_ERR}, 16'd0);
        end
        step();
        check("to_err",      {15'd0, FETCH_ERR}, 16'd1);
        check("to_mem_rd",   {15'd0, MEM_RD}, 16'd0);
        check("to_busy",     {15'd0, BUSY}, 16'd0);
        check("to_ir",       IR, 16'hBEEF);
        check("to_ir_pc",    IR_PC, 16'd13);
        check("to_ir_valid", {15'd0, IR_VALID}, 16'd0);
        // Late ready after the abort is ignored
        MEM_RDY = 1'b1; MEM_DATA = 16'h2222;
        step();
        check("to_late_ir",    IR, 16'hBEEF);
        check("to_late_valid", {15'd0, IR_VALID}, 16'd0);
        check("to_late_err",   {15'd0, FETCH_ERR}, 16'd1);
        MEM_RDY = 1'b0;
        // Next fetch clears the sticky flag
        PC = 16'd5; FETCH = 1'b1;
        step();
        check("to_clr_err",  {15'd0, FETCH_ERR}, 16'd0);
        check("to_clr_busy", {15'd0, BUSY}, 16'd1);
        FETCH = 1'b0; MEM_RDY = 1'b1; MEM_DATA = 16'h3333;
        step();
        check("to_next_ir",    IR, 16'h3333);
        check("to_next_ir_pc", IR_PC, 16'd5);
        MEM_RDY = 1'b0;

        // Ready exactly on the edge that would abort: data wins
        PC = 16'hFFFF; FETCH = 1'b1;
        step();
        FETCH = 1'b0;
        step(); step(); step();
        MEM_RDY = 1'b1; MEM_DATA = 16'h5A5A;
        step();
        check("lim_err",      {15'd0, FETCH_ERR}, 16'd0);
        check("lim_ir",       IR, 16'h5A5A);
        check("lim_ir_pc",    IR_PC, 16'hFFFF);
        check("lim_ir_valid", {15'd0, IR_VALID}, 16'd1);
        MEM_RDY = 1'b0;
`else
        // No timeout: a 300-cycle wait completes normally
        PC = 16'hFFFF; FETCH = 1'b1;
        step();
        FETCH = 1'b0;
        for (int i = 0; i < 300; i++) step();
        check("long_busy",   {15'd0, BUSY}, 16'd1);
        check("long_mem_rd", {15'd0, MEM_RD}, 16'd1);
        check("long_err",    {15'd0, FETCH_ERR}, 16'd0);
        MEM_RDY = 1'b1; MEM_DATA = 16'h5A5A;
        step();
        check("long_ir",       IR, 16'h5A5A);
        check("long_ir_pc",    IR_PC, 16'hFFFF);
        check("long_ir_valid", {15'd0, IR_VALID}, 16'd1);
        MEM_RDY = 1'b0;
`endif

        // Reset asserted in the 2nd wait cycle drops the read
        PC = 16'd7; FETCH = 1'b1;
        step();
        FETCH = 1'b0;
        step();
        RESET = 1'b1;
        step();
        check("mr_mem_rd",   {15'd0, MEM_RD}, 16'd0);
        check("mr_ir_valid", {15'd0, IR_VALID}, 16'd0);
        check("mr_busy",     {15'd0, BUSY}, 16'd0);
        check("mr_ir",       IR, 16'h0);
        RESET = 1'b0; MEM_RDY = 1'b1; MEM_DATA = 16'h4444;
        step();
        check("mr_late_ir",    IR, 16'h0);
        check("mr_late_valid", {15'd0, IR_VALID}, 16'd0);
        check("mr_late_busy",  {15'd0, BUSY}, 16'd0);
        MEM_RDY = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
